pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register that generalises the fixed ID/EX latch into a reusable stage for IF/ID, ID/EX, EX/MEM and MEM/WB.
- Carries a control bundle and a data bundle under a valid/ready handshake, with an optional 2-entry skid buffer.
- Supports a global memory stall, and a flush that inserts a bubble by zeroing the control bits.
- A flush that arrives during a stall is held pending and applied when the stall ends; a saturating counter reports bubble cycles.

Parameters:
- CTRL_W, 8, width of control bundle (wb/mem/ex bits); zeroed on flush/bubble
- DATA_W, 128, width of data bundle (pc, operands, imm, reg addrs); not cleared on flush
- SKID, 0, 0 = single register with combinational in_ready_o; 1 = 2-entry skid buffer with registered in_ready_o
- CNT_W, 16, width of bubble counter

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- stall_i  in  1  global memory stall; freezes stage contents
- flush_i  in  1  discard stage contents, insert bubble
- in_valid_i  in  1  upstream entry valid
- in_ready_o  out  1  stage can accept
- in_ctrl_i  in  CTRL_W  upstream control bundle
- in_data_i  in  DATA_W  upstream data bundle
- out_valid_o  out  1  output entry valid
- out_ready_i  in  1  downstream accepts
- out_ctrl_o  out  CTRL_W  control bundle; forced 0 when out_valid_o=0
- out_data_o  out  DATA_W  data bundle
- flush_pend_o  out  1  flush latched during stall, not yet applied
- bubble_cnt_o  out  CNT_W  saturating count of cycles with out_valid_o=0 and stall_i=0

Behaviour:
- Reset (async, rst_i=1): all entries invalid, out_ctrl_o=0, out_data_o=0, flush_pend_o=0, bubble_cnt_o=0, in_ready_o=0 while rst_i is high. First cycle after release: in_ready_o=1.
- Priority per edge: reset > stall > flush (or pending flush) > handshake.
- Stall, stall_i=1:
  - in_ready_o=0; no entry is written or popped.
  - out_valid_o, out_ctrl_o and out_data_o hold their values.
  - The bubble counter does not increment.
  - flush_i=1 during a stall sets flush_pend; it stays set until applied.
- Flush (flush_i=1 or flush_pend=1, with stall_i=0):
  - At the next edge all entries are invalidated, stored ctrl is cleared to 0, and flush_pend clears.
  - The input offered that cycle is dropped, even if in_valid_i=1.
  - in_ready_o=1 during the flush cycle, so upstream sees the input as consumed (upstream is flushed by the same signal).
- Handshake, SKID=0:
  - in_ready_o = ~out_valid_o | out_ready_i (when not stalled and not in reset).
  - Load when in_valid_i & in_ready_o; out_valid_o then goes high on the next edge.
  - A pop without a load clears out_valid_o.
  - Latency: 1 cycle.
- Handshake, SKID=1:
  - Two entries: main (drives the outputs) and skid.
  - in_ready_o = ~skid_valid, registered.
  - If input arrives while main is valid and out_ready_i=0, the input goes to skid.
  - On a pop, skid moves to main; a simultaneous load then goes to skid, or to main if skid was empty.
  - Order is strictly FIFO. Latency: 1 cycle when empty.
  - Full means skid_valid=1, so in_ready_o=0.
- Simultaneous pop and load on a full single register (SKID=0): the new entry replaces the old one in the same cycle, with no bubble.
- Bubble insertion: when out_valid_o=0, out_ctrl_o=0 regardless of stored state, so all write-enables are inert downstream.
- bubble_cnt_o:
  - +1 on each edge where out_valid_o=0 and stall_i=0.
  - Saturates at 2^CNT_W-1; there is no wrap.
- Reset mid-stall or mid-flush-pending: everything clears immediately; the pending flush is discarded.

Decomposition:
- Shared package pipe_pkg holds:
  - Per-stage CTRL_W/DATA_W constants (IDEX_CTRL_W = 8: wb[1:0], mem[1:0], ex[3:0]).
  - Field offset constants for slicing the ctrl/data bundles.
  - The bubble ctrl value (all zero).
- One sub-module, pipe_skid_buf, implements the 2-entry skid storage; it is instantiated under a SKID=1 generate branch.
- The stall/flush/counter logic stays in the top module.

Test Plan:
- Reset: assert rst_i asynchronously mid-cycle while out_valid_o=1 and ctrl=0xA5 -> out_valid_o=0, out_ctrl_o=0x00 and bubble_cnt_o=0 immediately; after release, in_ready_o=1.
- Streaming (SKID=0, out_ready_i=1): push ctrl 0x01..0x05 on consecutive cycles -> same values appear on out_ctrl_o one cycle later, in order, with no gaps, and bubble_cnt_o unchanged.
- Stall hold: with data 0xDEAD in the stage, hold stall_i=1 for 4 cycles while in_valid_i=1 carries 0xBEEF -> out_data_o=0xDEAD throughout, in_ready_o=0, and 0xBEEF is loaded only on the first non-stall edge.
- Flush during stall: hold stall_i=1 and pulse flush_i for 1 cycle -> flush_pend_o=1 and outputs held; on the first edge after stall_i drops -> out_valid_o=0, out_ctrl_o=0, flush_pend_o=0, and the input on that cycle is dropped.
- Skid backpressure (SKID=1): hold out_ready_i=0 and push A, B, C -> A on the output, B in skid, in_ready_o=0 so C is held upstream; release out_ready_i -> outputs A, B, C in order, each exactly once.
- Counter saturation (CNT_W=4): idle for 20 unstalled cycles -> bubble_cnt_o stops at 15 and does not wrap.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared widths, bundle field offsets and bubble value for the pipe_stage_reg
// pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
package pipe_pkg;

   typedef enum logic [1:0] {
      STAGE_IFID  = 2'd0,
      STAGE_IDEX  = 2'd1,
      STAGE_EXMEM = 2'd2,
      STAGE_MEMWB = 2'd3
   } stage_e;

   localparam int IFID_CTRL_W  = 2;
   localparam int IFID_DATA_W  = 64;
   localparam int IDEX_CTRL_W  = 8;
   localparam int IDEX_DATA_W  = 128;
   localparam int EXMEM_CTRL_W = 4;
   localparam int EXMEM_DATA_W = 101;
   localparam int MEMWB_CTRL_W = 2;
   localparam int MEMWB_DATA_W = 69;

   // ID/EX control bundle: wb[7:6], mem[5:4], ex[3:0]
   typedef struct packed {
      logic [1:0] wb;
      logic [1:0] mem;
      logic [3:0] ex;
   } idex_ctrl_t;

   localparam int IDEX_EX_LSB  = 0;
   localparam int IDEX_MEM_LSB = 4;
   localparam int IDEX_WB_LSB  = 6;

   // ID/EX data bundle: pc, rs1/rs2 values, imm, rs1/rs2/rd addresses
   localparam int IDEX_PC_LSB  = 96;
   localparam int IDEX_RS1_LSB = 64;
   localparam int IDEX_RS2_LSB = 32;
   localparam int IDEX_IMM_LSB = 15;
   localparam int IDEX_RA1_LSB = 10;
   localparam int IDEX_RA2_LSB = 5;
   localparam int IDEX_RD_LSB  = 0;

   // A bubble is an entry whose every control bit is inert.
   localparam logic       BUBBLE_BIT       = 1'b0;
   localparam idex_ctrl_t IDEX_BUBBLE_CTRL = '0;

   function automatic int stage_ctrl_w(stage_e s);
      case (s)
         STAGE_IFID:  return IFID_CTRL_W;
         STAGE_IDEX:  return IDEX_CTRL_W;
         STAGE_EXMEM: return EXMEM_CTRL_W;
         default:     return MEMWB_CTRL_W;
      endcase
   endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid storage: "main" drives the stage outputs, "skid" catches one
// extra entry while downstream is back-pressuring. Strict FIFO order.
module pipe_skid_buf
   import pipe_pkg::*;
#(
   parameter int CTRL_W = IDEX_CTRL_W,
   parameter int DATA_W = IDEX_DATA_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_hold,
   input  logic              i_clear,
   input  logic              i_load,
   input  logic              i_pop,
   input  logic [CTRL_W-1:0] i_ctrl,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_main_valid,
   output logic [CTRL_W-1:0] o_main_ctrl,
   output logic [DATA_W-1:0] o_main_data,
   output logic              o_skid_valid
);

   logic              r_main_valid;
   logic [CTRL_W-1:0] r_main_ctrl;
   logic [DATA_W-1:0] r_main_data;
   logic              r_skid_valid;
   logic [CTRL_W-1:0] r_skid_ctrl;
   logic [DATA_W-1:0] r_skid_data;

   // NOTE: non-blocking assignments, so main <= skid and skid <= input in the
   // same edge both see the pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_main_valid <= 1'b0;
         r_main_ctrl  <= '0;
         r_main_data  <= '0;
         r_skid_valid <= 1'b0;
         r_skid_ctrl  <= '0;
         r_skid_data  <= '0;
      end else if (!i_hold) begin
         if (i_clear) begin
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
         end else if (i_pop) begin
            if (r_skid_valid) begin
               r_main_ctrl <= r_skid_ctrl;
               r_main_data <= r_skid_data;
               if (i_load) begin
                  r_skid_ctrl <= i_ctrl;
                  r_skid_data <= i_data;
               end else begin
                  r_skid_valid <= 1'b0;
               end
            end else if (i_load) begin
               r_main_ctrl <= i_ctrl;
               r_main_data <= i_data;
            end else begin
               r_main_valid <= 1'b0;
            end
         end else if (i_load) begin
            if (r_main_valid) begin
               r_skid_valid <= 1'b1;
               r_skid_ctrl  <= i_ctrl;
               r_skid_data  <= i_data;
            end else begin
               r_main_valid <= 1'b1;
               r_main_ctrl  <= i_ctrl;
               r_main_data  <= i_data;
            end
         end
      end
   end

   assign o_main_valid = r_main_valid;
   assign o_main_ctrl  = r_main_ctrl;
   assign o_main_data  = r_main_data;
   assign o_skid_valid = r_skid_valid;

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage latch with valid/ready handshake, global stall,
// flush-to-bubble (deferred while stalled) and a saturating bubble counter.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int CTRL_W = IDEX_CTRL_W,
   parameter int DATA_W = IDEX_DATA_W,
   parameter int SKID   = 0,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [CTRL_W-1:0] out_ctrl_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic              flush_pend_o,
   output logic [CNT_W-1:0]  bubble_cnt_o
);

   logic              r_flush_pend;
   logic [CNT_W-1:0]  r_bubble_cnt;
   logic              w_flush;
   logic              w_advance;
   logic              w_space;
   logic              w_load;
   logic              w_pop;
   logic              w_valid;
   logic [CTRL_W-1:0] w_ctrl;
   logic [DATA_W-1:0] w_data;

   assign w_flush   = flush_i | r_flush_pend;
   assign w_advance = ~stall_i & ~w_flush;

   // During a flush the offered input is reported consumed and then dropped.
   assign in_ready_o = ~rst_i & ~stall_i & (w_flush | w_space);
   assign w_load     = in_valid_i & in_ready_o & w_advance;
   assign w_pop      = w_valid & out_ready_i & w_advance;

   generate
      if (SKID == 0) begin : g_reg
         logic              r_valid;
         logic [CTRL_W-1:0] r_ctrl;
         logic [DATA_W-1:0] r_data;

         assign w_space = ~r_valid | out_ready_i;

         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               r_valid <= 1'b0;
               r_ctrl  <= '0;
               r_data  <= '0;
            end else if (!stall_i) begin
               if (w_flush) begin
                  r_valid <= 1'b0;
                  r_ctrl  <= '0;
               end else if (w_load) begin
                  r_valid <= 1'b1;
                  r_ctrl  <= in_ctrl_i;
                  r_data  <= in_data_i;
               end else if (w_pop) begin
                  r_valid <= 1'b0;
               end
            end
         end

         assign w_valid = r_valid;
         assign w_ctrl  = r_ctrl;
         assign w_data  = r_data;
      end else begin : g_skid
         logic w_skid_valid;

         pipe_skid_buf #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W)
         ) u_skid (
            .i_clk        (clk_i),
            .i_rst        (rst_i),
            .i_hold       (stall_i),
            .i_clear      (w_flush),
            .i_load       (w_load),
            .i_pop        (w_pop),
            .i_ctrl       (in_ctrl_i),
            .i_data       (in_data_i),
            .o_main_valid (w_valid),
            .o_main_ctrl  (w_ctrl),
            .o_main_data  (w_data),
            .o_skid_valid (w_skid_valid)
         );

         assign w_space = ~w_skid_valid;
      end
   endgenerate

   // A flush seen while stalled is remembered; any unstalled edge applies it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_flush_pend <= 1'b0;
         r_bubble_cnt <= '0;
      end else begin
         r_flush_pend <= stall_i & (r_flush_pend | flush_i);
         if (!stall_i && !w_valid && !(&r_bubble_cnt)) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
         end
      end
   end

   assign out_valid_o  = w_valid;
   assign out_ctrl_o   = w_valid ? w_ctrl : {CTRL_W{BUBBLE_BIT}};
   assign out_data_o   = w_data;
   assign flush_pend_o = r_flush_pend;
   assign bubble_cnt_o = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a single-register and a skid instance
// share stimulus; each is compared against a capacity-limited FIFO model.
module tb_pipe_stage_reg;

   localparam int CW      = 8;
   localparam int DW      = 64;
   localparam int NW      = 4;
   localparam int CNT_MAX = (1 << NW) - 1;

   typedef struct packed {
      logic [CW-1:0] ctrl;
      logic [DW-1:0] data;
   } entry_t;

   logic          clk_i       = 1'b0;
   logic          rst_i       = 1'b1;
   logic          stall_i     = 1'b0;
   logic          flush_i     = 1'b0;
   logic          in_valid_i  = 1'b0;
   logic          out_ready_i = 1'b0;
   logic [CW-1:0] in_ctrl_i   = '0;
   logic [DW-1:0] in_data_i   = '0;

   logic [1:0]    o_ready;
   logic [1:0]    o_valid;
   logic [1:0]    o_pend;
   logic [CW-1:0] o_ctrl [2];
   logic [DW-1:0] o_data [2];
   logic [NW-1:0] o_cnt  [2];

   // Model: stage contents as a FIFO of capacity 1 (SKID=0) or 2 (SKID=1).
   entry_t mq   [2][2];
   int     occ  [2];
   bit     pend [2];
   int     cnt  [2];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_i = ~clk_i;

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(NW)) dut0 (
      .clk_i (clk_i), .rst_i (rst_i), .stall_i (stall_i), .flush_i (flush_i),
      .in_valid_i (in_valid_i), .in_ready_o (o_ready[0]),
      .in_ctrl_i (in_ctrl_i), .in_data_i (in_data_i),
      .out_valid_o (o_valid[0]), .out_ready_i (out_ready_i),
      .out_ctrl_o (o_ctrl[0]), .out_data_o (o_data[0]),
      .flush_pend_o (o_pend[0]), .bubble_cnt_o (o_cnt[0])
   );

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(NW)) dut1 (
      .clk_i (clk_i), .rst_i (rst_i), .stall_i (stall_i), .flush_i (flush_i),
      .in_valid_i (in_valid_i), .in_ready_o (o_ready[1]),
      .in_ctrl_i (in_ctrl_i), .in_data_i (in_data_i),
      .out_valid_o (o_valid[1]), .out_ready_i (out_ready_i),
      .out_ctrl_o (o_ctrl[1]), .out_data_o (o_data[1]),
      .flush_pend_o (o_pend[1]), .bubble_cnt_o (o_cnt[1])
   );

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         occ[k]  = 0;
         pend[k] = 1'b0;
         cnt[k]  = 0;
      end
   endtask

   // Monitor: whenever the DUT presents an entry it must match the head of
   // the expected queue; status outputs are compared alongside.
   always @(negedge clk_i) begin
      #2;
      if (!rst_i) begin
         for (int k = 0; k < 2; k++) begin
            check($sformatf("out_valid dut%0d", k), DW'(o_valid[k]), DW'(occ[k] > 0));
            check($sformatf("out_ctrl dut%0d", k), DW'(o_ctrl[k]),
                  DW'((occ[k] > 0) ? mq[k][0].ctrl : '0));
            if (o_valid[k] && occ[k] > 0)
               check($sformatf("out_data dut%0d", k), o_data[k], mq[k][0].data);
            check($sformatf("flush_pend dut%0d", k), DW'(o_pend[k]), DW'(pend[k]));
            check($sformatf("bubble_cnt dut%0d", k), DW'(o_cnt[k]), DW'(cnt[k]));
         end
      end
   end

   // One clock of stimulus; issues inputs, predicts acceptance, updates model.
   task automatic cycle(input logic st, input logic fl, input logic iv,
                        input logic [CW-1:0] c, input logic [DW-1:0] d, input logic ordy);
      bit fe [2];
      bit pop [2];
      bit acc [2];
      bit bub [2];
      bit room;
      bit rdy;
      @(negedge clk_i);
      stall_i     = st;
      flush_i     = fl;
      in_valid_i  = iv;
      in_ctrl_i   = c;
      in_data_i   = d;
      out_ready_i = ordy;
      #1;
      for (int k = 0; k < 2; k++) begin
         fe[k]  = fl | pend[k];
         room   = (k == 0) ? (occ[k] == 0 || ordy) : (occ[k] < 2);
         rdy    = !st && (fe[k] || room);
         check($sformatf("in_ready dut%0d", k), DW'(o_ready[k]), DW'(rdy));
         pop[k] = !st && !fe[k] && occ[k] > 0 && ordy;
         acc[k] = rdy && iv && !fe[k];
         bub[k] = !st && occ[k] == 0;
      end
      @(posedge clk_i);
      for (int k = 0; k < 2; k++) begin
         if (st) begin
            if (fl) pend[k] = 1'b1;
         end else if (fe[k]) begin
            occ[k]  = 0;
            pend[k] = 1'b0;
         end else begin
            if (pop[k]) begin
               mq[k][0] = mq[k][1];
               occ[k]--;
            end
            if (acc[k]) begin
               mq[k][occ[k]] = '{ctrl: c, data: d};
               occ[k]++;
            end
         end
         if (bub[k] && cnt[k] < CNT_MAX) cnt[k]++;
      end
   endtask

   // Asynchronous reset asserted mid-cycle; released just after a rising edge.
   task automatic do_reset();
      @(negedge clk_i);
      #3;
      rst_i = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("rst out_valid dut%0d", k), DW'(o_valid[k]), '0);
         check($sformatf("rst out_ctrl dut%0d", k), DW'(o_ctrl[k]), '0);
         check($sformatf("rst out_data dut%0d", k), o_data[k], '0);
         check($sformatf("rst bubble_cnt dut%0d", k), DW'(o_cnt[k]), '0);
         check($sformatf("rst flush_pend dut%0d", k), DW'(o_pend[k]), '0);
         check($sformatf("rst in_ready dut%0d", k), DW'(o_ready[k]), '0);
      end
      model_clear();
      stall_i    = 1'b0;
      flush_i    = 1'b0;
      in_valid_i = 1'b0;
      @(posedge clk_i);
      @(posedge clk_i);
      #2;
      rst_i = 1'b0;
      #1;
      for (int k = 0; k < 2; k++)
         check($sformatf("post-rst in_ready dut%0d", k), DW'(o_ready[k]), DW'(1));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      model_clear();
      do_reset();

      // Reset while an entry with ctrl 0xA5 is on the output.
      cycle(0, 0, 1, 8'hA5, 64'h5A5A, 1);
      do_reset();

      // Back-to-back streaming.
      for (int i = 1; i <= 5; i++) cycle(0, 0, 1, CW'(i), DW'(64'h100 + i), 1);
      repeat (2) cycle(0, 0, 0, '0, '0, 1);

      // Stall holds 0xDEAD while 0xBEEF waits upstream.
      cycle(0, 0, 1, 8'h11, 64'hDEAD, 1);
      repeat (4) cycle(1, 0, 1, 8'h22, 64'hBEEF, 1);
      cycle(0, 0, 1, 8'h22, 64'hBEEF, 1);
      cycle(0, 0, 0, '0, '0, 0);
      cycle(0, 0, 0, '0, '0, 1);

      // Flush during stall is deferred, then drops the stage and the input.
      cycle(0, 0, 1, 8'h33, 64'hC0DE, 0);
      cycle(1, 0, 1, 8'h44, 64'h4444, 0);
      cycle(1, 1, 1, 8'h44, 64'h4444, 0);
      cycle(1, 0, 1, 8'h44, 64'h4444, 0);
      cycle(0, 0, 1, 8'h55, 64'hF00D, 1);
      cycle(0, 0, 0, '0, '0, 1);

      // Reset while a flush is pending discards it.
      cycle(0, 0, 1, 8'h66, 64'h6666, 0);
      cycle(1, 1, 0, '0, '0, 0);
      do_reset();

      // Skid back-pressure: A, B stored, C held off until space frees up.
      cycle(0, 0, 1, 8'h0A, 64'hAAAA, 0);
      cycle(0, 0, 1, 8'h0B, 64'hBBBB, 0);
      repeat (3) cycle(0, 0, 1, 8'h0C, 64'hCCCC, 0);
      repeat (2) cycle(0, 0, 1, 8'h0C, 64'hCCCC, 1);
      repeat (3) cycle(0, 0, 0, '0, '0, 1);

      // Counter saturation.
      do_reset();
      repeat (20) cycle(0, 0, 0, '0, '0, 1);
      #1;
      check("bubble saturate dut0", DW'(o_cnt[0]), DW'(CNT_MAX));
      check("bubble saturate dut1", DW'(o_cnt[1]), DW'(CNT_MAX));

      // Randomised traffic.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5,
               $urandom_range(0, 99) < 60, CW'($urandom()),
               {$urandom(), $urandom()}, $urandom_range(0, 99) < 65);
      end
      repeat (4) cycle(0, 0, 0, '0, '0, 1);

      @(negedge clk_i);
      #3;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
